// File: rtl/periph_rx_scheduler.sv
// Round-robin scheduler sharing the FT601 upstream path between peripheral RX FIFOs.
// Grants are bounded bursts; almost-full peripherals win arbitration in IDLE.
module periph_rx_scheduler #(
    parameter int unsigned NUM_PERIPHS = 8,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned GRANT_W     = (NUM_PERIPHS > 1) ? $clog2(NUM_PERIPHS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_PERIPHS-1:0]       rx_empty,
    input  logic [NUM_PERIPHS-1:0]       rx_almost_full,
    input  logic [NUM_PERIPHS*WIDTH-1:0] rx_data,
    output logic [NUM_PERIPHS-1:0]       rx_read,
    output logic [WIDTH-1:0]             data_o,
    output logic                         periph_data_available,
    input  logic                         read_periph_data,
    output logic [GRANT_W-1:0]           grant,
    output logic                         busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [GRANT_W-1:0]   grant_nxt;
    logic [GRANT_W-1:0]   last_grant;
    logic [GRANT_W-1:0]   last_grant_nxt;
    logic [GRANT_W-1:0]   winner;
    logic [CNT_W-1:0]     burst_cnt;
    logic [CNT_W-1:0]     burst_cnt_nxt;
    logic [NUM_PERIPHS-1:0] req;
    logic [NUM_PERIPHS-1:0] urgent;
    logic [NUM_PERIPHS-1:0] pick;
    logic                 found;
    logic                 head_valid;
    logic                 do_read;
    int unsigned          idx;
    logic [WIDTH-1:0]     rx_words [NUM_PERIPHS];

    for (genvar g = 0; g < NUM_PERIPHS; g++) begin : g_unpack
        assign rx_words[g] = rx_data[g*WIDTH +: WIDTH];
    end

    assign req    = ~rx_empty;
    assign urgent = req & rx_almost_full;
    assign pick   = (|urgent) ? urgent : req;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 1; i <= NUM_PERIPHS; i++) begin
            idx = (32'(last_grant) + i) % NUM_PERIPHS;
            if (!found && pick[GRANT_W'(idx)]) begin
                found  = 1'b1;
                winner = GRANT_W'(idx);
            end
        end
    end

    assign busy                  = (state == GRANTED);
    assign head_valid            = busy && !rx_empty[grant];
    assign do_read               = head_valid && read_periph_data;
    assign periph_data_available = head_valid;
    assign data_o                = rx_words[grant];

    always_comb begin
        rx_read        = '0;
        rx_read[grant] = do_read;
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (enable && found) begin
                    state_nxt      = GRANTED;
                    grant_nxt      = winner;
                    last_grant_nxt = winner;
                    burst_cnt_nxt  = '0;
                end
            end
            GRANTED: begin
                // An empty head ends the burst; so does the final read of a full burst.
                if (rx_empty[grant]) begin
                    state_nxt = IDLE;
                end else if (do_read) begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                    if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GRANT_W'(NUM_PERIPHS - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

endmodule
